game_round_ctrl: RTL and testbench

- Round controller for the goal-scoring game.
- Consumes the debounced, one-cycle `start_p` and `goal_p` pulses. Runs a READY countdown, then a timed PLAY period, and counts goals only during PLAY.
- Drives four BCD digits (time tens/ones, score tens/ones) into the 4-digit display multiplexer and 7-segment decoder.
- Sits between the debounce/one-pulse stage and the display stage.

---
 rtl/game_round_ctrl_pkg.sv | 26 ++
 rtl/game_round_ctrl_if.sv | 24 ++
 rtl/game_round_ctrl_bcd2_counter.sv | 50 +++++
 rtl/game_round_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_round_ctrl.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the goal-game round controller.
package game_round_ctrl_pkg;

  localparam int unsigned DigitW = 4;
  localparam logic [DigitW-1:0] Dash = 4'd10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StReady  = 2'd1,
    StPlay   = 2'd2,
    StFinish = 2'd3
  } state_e;

  typedef struct packed {
    logic [DigitW-1:0] tens;
    logic [DigitW-1:0] ones;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(int unsigned v);
    bcd2_t r;
    r.tens = DigitW'((v / 10) % 10);
    r.ones = DigitW'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Pulse inputs and display/status outputs of the round controller.
interface game_round_ctrl_if;
  import game_round_ctrl_pkg::*;

  logic              start_p;
  logic              goal_p;
  logic [1:0]        state_o;
  logic [DigitW-1:0] disp_d3;
  logic [DigitW-1:0] disp_d2;
  logic [DigitW-1:0] disp_d1;
  logic [DigitW-1:0] disp_d0;
  logic              done_o;

  modport master (
    output start_p, goal_p,
    input  state_o, disp_d3, disp_d2, disp_d1, disp_d0, done_o
  );

  modport slave (
    input  start_p, goal_p,
    output state_o, disp_d3, disp_d2, disp_d1, disp_d0, done_o
  );

endinterface

// File: rtl/game_round_ctrl_bcd2_counter.sv
// Two-digit BCD counter: load, saturating increment at 99, decrement with borrow (holds at 00).
module bcd2_counter
  import game_round_ctrl_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  load_i,
  input  bcd2_t load_val_i,
  input  logic  inc_i,
  input  logic  dec_i,
  output bcd2_t cnt_o,
  output bcd2_t cnt_d_o
);

  bcd2_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      if (cnt_q != 8'h99) begin
        if (cnt_q.ones == 4'd9) begin
          cnt_d.ones = 4'd0;
          cnt_d.tens = cnt_q.tens + 4'd1;
        end else begin
          cnt_d.ones = cnt_q.ones + 4'd1;
        end
      end
    end else if (dec_i) begin
      if (cnt_q != 8'h00) begin
        if (cnt_q.ones == 4'd0) begin
          cnt_d.ones = 4'd9;
          cnt_d.tens = cnt_q.tens - 4'd1;
        end else begin
          cnt_d.ones = cnt_q.ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller: READY countdown, timed PLAY with BCD goal count, FINISH hold.
// Optional best-score tracking when HIGH_SCORE_EN is defined.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned READY_SEC = 3,
  parameter int unsigned PLAY_SEC  = 60
) (
  input  logic              clk,
  input  logic              rst,
  game_round_ctrl_if.slave  bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam bcd2_t ReadyBcd = to_bcd2(READY_SEC);
  localparam bcd2_t PlayBcd  = to_bcd2(PLAY_SEC);

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick, presc_clr;
  logic              t_load, t_dec, s_clr, s_inc;
  bcd2_t             t_val;
  bcd2_t             time_q, time_d, score_q, score_d;
  logic [DigitW-1:0] disp_q [4];
  logic [DigitW-1:0] disp_d [4];
  logic              done_q;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  bcd2_counter u_time (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (t_load),
    .load_val_i (t_val),
    .inc_i      (1'b0),
    .dec_i      (t_dec),
    .cnt_o      (time_q),
    .cnt_d_o    (time_d)
  );

  bcd2_counter u_score (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (s_clr),
    .load_val_i ('0),
    .inc_i      (s_inc),
    .dec_i      (1'b0),
    .cnt_o      (score_q),
    .cnt_d_o    (score_d)
  );

  always_comb begin
    state_d   = state_q;
    t_load    = 1'b0;
    t_val     = PlayBcd;
    t_dec     = 1'b0;
    s_clr     = 1'b0;
    s_inc     = 1'b0;
    presc_clr = 1'b0;
    unique case (state_q)
      StIdle, StFinish: begin
        if (bus.start_p) begin
          state_d   = StReady;
          t_load    = 1'b1;
          t_val     = ReadyBcd;
          s_clr     = 1'b1;
          presc_clr = 1'b1;
        end
      end
      StReady: begin
        if (tick) begin
          if (time_q == 8'h01) begin
            state_d = StPlay;
            t_load  = 1'b1;
          end else begin
            t_dec = 1'b1;
          end
        end
      end
      StPlay: begin
        s_inc = bus.goal_p && (score_q != 8'h99);
        if (tick) begin
          t_dec = 1'b1;
          if (time_q == 8'h01) state_d = StFinish;
        end
      end
      default: ;
    endcase
    presc_d = (tick || presc_clr) ? '0 : presc_q + PW'(1);
  end

`ifdef HIGH_SCORE_EN
  bcd2_t best_q, best_d;

  // BCD digits compare correctly as a plain 8-bit value.
  always_comb begin
    best_d = best_q;
    if (state_q == StPlay && state_d == StFinish && score_d > best_q) best_d = score_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) best_q <= '0;
    else      best_q <= best_d;
  end
`endif

  // Display is decoded from next-state values so it registers alongside the state.
  always_comb begin
    for (int i = 0; i < 4; i++) disp_d[i] = Dash;
    unique case (state_d)
      StIdle: begin
`ifdef HIGH_SCORE_EN
        disp_d[1] = best_d.tens;
        disp_d[0] = best_d.ones;
`endif
      end
      StReady: disp_d[2] = time_d.ones;
      StPlay, StFinish: begin
        disp_d[3] = time_d.tens;
        disp_d[2] = time_d.ones;
        disp_d[1] = score_d.tens;
        disp_d[0] = score_d.ones;
`ifdef HIGH_SCORE_EN
        if (state_d == StFinish) begin
          disp_d[3] = best_d.tens;
          disp_d[2] = best_d.ones;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      presc_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) disp_q[i] <= Dash;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      done_q  <= (state_d == StFinish);
      for (int i = 0; i < 4; i++) disp_q[i] <= disp_d[i];
    end
  end

  assign bus.state_o = state_q;
  assign bus.done_o  = done_q;
  assign bus.disp_d3 = disp_q[3];
  assign bus.disp_d2 = disp_q[2];
  assign bus.disp_d1 = disp_q[1];
  assign bus.disp_d0 = disp_q[0];

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: two instances (PLAY_SEC=12 and PLAY_SEC=99), TICK_DIV=4.
module tb_game_round_ctrl;

`ifdef HIGH_SCORE_EN
  localparam bit Hse = 1'b1;
`else
  localparam bit Hse = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  game_round_ctrl_if bus_a ();
  game_round_ctrl_if bus_b ();

  game_round_ctrl #(.TICK_DIV(4), .READY_SEC(3), .PLAY_SEC(12)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  game_round_ctrl #(.TICK_DIV(4), .READY_SEC(3), .PLAY_SEC(99)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic disp_a(string tag, int e3, int e2, int e1, int e0);
    chk({tag, ".d3"}, 32'(bus_a.disp_d3), e3);
    chk({tag, ".d2"}, 32'(bus_a.disp_d2), e2);
    chk({tag, ".d1"}, 32'(bus_a.disp_d1), e1);
    chk({tag, ".d0"}, 32'(bus_a.disp_d0), e0);
  endtask

  task automatic disp_b(string tag, int e3, int e2, int e1, int e0);
    chk({tag, ".d3"}, 32'(bus_b.disp_d3), e3);
    chk({tag, ".d2"}, 32'(bus_b.disp_d2), e2);
    chk({tag, ".d1"}, 32'(bus_b.disp_d1), e1);
    chk({tag, ".d0"}, 32'(bus_b.disp_d0), e0);
  endtask

  initial begin
    rst = 1'b0;
    bus_a.start_p = 1'b0; bus_a.goal_p = 1'b0;
    bus_b.start_p = 1'b0; bus_b.goal_p = 1'b0;
    cyc(2);
    chk("rst_state", 32'(bus_a.state_o), 0);
    chk("rst_done", 32'(bus_a.done_o), 0);
    disp_a("rst_disp", 10, 10, 10, 10);
    chk("rst_state_b", 32'(bus_b.state_o), 0);
    rst = 1'b1;
    cyc(1);
    disp_a("idle_disp", 10, 10, Hse ? 0 : 10, Hse ? 0 : 10);

    // Round 1: start, then a goal during READY which must be ignored.
    bus_a.start_p = 1'b1; cyc(1); bus_a.start_p = 1'b0;
    chk("ready_state", 32'(bus_a.state_o), 1);
    disp_a("ready3", 10, 3, 10, 10);
    bus_a.goal_p = 1'b1; cyc(1); bus_a.goal_p = 1'b0;
    cyc(2);
    disp_a("ready3_hold", 10, 3, 10, 10);
    cyc(1);
    chk("ready2", 32'(bus_a.disp_d2), 2);
    cyc(4);
    chk("ready1", 32'(bus_a.disp_d2), 1);
    cyc(3);
    chk("ready_e11", 32'(bus_a.state_o), 1);
    cyc(1);
    chk("play_state", 32'(bus_a.state_o), 2);
    disp_a("play_entry", 1, 2, 0, 0);

    for (int i = 0; i < 3; i++) begin
      bus_a.goal_p = 1'b1; cyc(1);
    end
    bus_a.goal_p = 1'b0;
    disp_a("three_goals", 1, 2, 0, 3);
    cyc(1);
    disp_a("time11", 1, 1, 0, 3);
    cyc(8);
    disp_a("time_borrow09", 0, 9, 0, 3);
    cyc(35);
    chk("pre_final_state", 32'(bus_a.state_o), 2);
    disp_a("pre_final", 0, 1, 0, 3);
    bus_a.goal_p = 1'b1; cyc(1); bus_a.goal_p = 1'b0;
    chk("finish_state", 32'(bus_a.state_o), 3);
    chk("finish_done", 32'(bus_a.done_o), 1);
    disp_a("final_goal_counted", 0, Hse ? 4 : 0, 0, 4);
    bus_a.goal_p = 1'b1; cyc(1); bus_a.goal_p = 1'b0;
    cyc(5);
    chk("finish_hold_state", 32'(bus_a.state_o), 3);
    chk("finish_hold_done", 32'(bus_a.done_o), 1);
    disp_a("finish_hold", 0, Hse ? 4 : 0, 0, 4);

    // Round 2: start and goal together; start wins and the goal is dropped.
    bus_a.start_p = 1'b1; bus_a.goal_p = 1'b1; cyc(1);
    bus_a.start_p = 1'b0; bus_a.goal_p = 1'b0;
    chk("r2_ready", 32'(bus_a.state_o), 1);
    chk("r2_done_clr", 32'(bus_a.done_o), 0);
    disp_a("r2_ready3", 10, 3, 10, 10);
    cyc(12);
    chk("r2_play", 32'(bus_a.state_o), 2);
    disp_a("r2_play_entry", 1, 2, 0, 0);
    bus_a.goal_p = 1'b1; cyc(1); bus_a.goal_p = 1'b0; cyc(1);
    bus_a.goal_p = 1'b1; cyc(1); bus_a.goal_p = 1'b0;
    disp_a("r2_two_goals", 1, 2, 0, 2);
    cyc(45);
    chk("r2_finish", 32'(bus_a.state_o), 3);
    disp_a("r2_finish_disp", 0, Hse ? 4 : 0, 0, 2);

    // Round 3: reset mid-PLAY with score 05 and a goal in the reset cycle.
    bus_a.start_p = 1'b1; cyc(1); bus_a.start_p = 1'b0;
    cyc(12);
    chk("r3_play", 32'(bus_a.state_o), 2);
    bus_a.goal_p = 1'b1; cyc(5); bus_a.goal_p = 1'b0;
    disp_a("r3_score5", 1, 1, 0, 5);
    rst = 1'b0; bus_a.goal_p = 1'b1; cyc(1);
    rst = 1'b1; bus_a.goal_p = 1'b0;
    chk("midrst_state", 32'(bus_a.state_o), 0);
    chk("midrst_done", 32'(bus_a.done_o), 0);
    disp_a("midrst_disp", 10, 10, 10, 10);
    bus_a.start_p = 1'b1; cyc(1); bus_a.start_p = 1'b0;
    chk("restart_ready", 32'(bus_a.state_o), 1);
    cyc(12);
    chk("restart_play", 32'(bus_a.state_o), 2);
    disp_a("restart_score0", 1, 2, 0, 0);

    // Instance B: 100 consecutive goals, carries and saturation at 99.
    bus_b.start_p = 1'b1; cyc(1); bus_b.start_p = 1'b0;
    cyc(12);
    chk("b_play", 32'(bus_b.state_o), 2);
    disp_b("b_play_entry", 9, 9, 0, 0);
    bus_b.goal_p = 1'b1;
    cyc(10);
    chk("b_carry10_d1", 32'(bus_b.disp_d1), 1);
    chk("b_carry10_d0", 32'(bus_b.disp_d0), 0);
    cyc(10);
    chk("b_carry20_d1", 32'(bus_b.disp_d1), 2);
    chk("b_carry20_d0", 32'(bus_b.disp_d0), 0);
    cyc(80);
    chk("b_sat_d1", 32'(bus_b.disp_d1), 9);
    chk("b_sat_d0", 32'(bus_b.disp_d0), 9);
    cyc(5);
    bus_b.goal_p = 1'b0;
    chk("b_state_after", 32'(bus_b.state_o), 2);
    disp_b("b_sat_hold", 7, 3, 9, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
